// File: rtl/video_line_fetch.sv
`default_nettype none
//==============================================================================
// Module   : video_line_fetch
// Brief    : Prefetches each visible line into one half of a ping-pong line buffer.
//            Define VIDEO_LINE_FETCH_DOUBLE_EN to show every memory line twice.
// Revision : 1.0 - initial release
//==============================================================================
module video_line_fetch #(
    parameter int LINE_WORDS = 640,
    parameter int HEIGHT     = 480,
    parameter int STRIDE     = 2560
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [31:0] i_base,
    input  logic        i_vsync,
    input  logic        i_data_enable,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_lb_write,
    output logic [11:0] o_lb_address,
    output logic [31:0] o_lb_wdata,
    output logic        o_read_bank,
    output logic        o_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_START = 2'd1,
        PEND_STOP  = 2'd2,
        PEND_NEXT  = 2'd3
    } pend_t;

    localparam logic [10:0] c_last_word = 11'(LINE_WORDS - 1);
    localparam logic [11:0] c_height    = 12'(HEIGHT);
    localparam logic [31:0] c_stride    = 32'(STRIDE);

    state_t      r_state;
    pend_t       r_pend;
    logic        r_vs_prev;
    logic        r_de_prev;
    logic [10:0] r_line;
    logic [10:0] r_word;
    logic [31:0] r_base;
    logic [31:0] r_line_addr;
    logic        r_bus_request;
    logic [31:0] r_bus_address;
    logic        r_lb_write;
    logic [11:0] r_lb_address;
    logic [31:0] r_lb_wdata;
    logic        r_read_bank;
    logic        r_underrun;

    logic        w_vs_rise;
    logic        w_de_rise;
    logic        w_line_event;
    logic        w_accept;
    logic        w_beat_stuck;
    logic [11:0] w_line_inc;
    logic        w_more_lines;
    logic [31:0] w_next_line_addr;
    logic        w_do_start;
    logic        w_do_stop;
    logic        w_do_next;
    logic [31:0] w_start_base;

    assign w_vs_rise        = i_vsync & ~r_vs_prev;
    assign w_de_rise        = i_data_enable & ~r_de_prev & ~w_vs_rise;
    assign w_accept         = r_bus_request & i_bus_ready;
    assign w_beat_stuck     = r_bus_request & ~i_bus_ready;
    assign w_line_inc       = {1'b0, r_line} + 12'd1;
    assign w_more_lines     = (w_line_inc < c_height);
    assign w_next_line_addr = r_line_addr + c_stride;

`ifdef VIDEO_LINE_FETCH_DOUBLE_EN
    logic r_parity;

    // Only the second data-enable edge of each pair advances to the next memory line
    assign w_line_event = w_de_rise & r_parity;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_parity <= 1'b0;
        end else if (w_do_start) begin
            r_parity <= 1'b0;
        end else if (w_de_rise && (r_state == ST_FETCH || r_state == ST_WAIT)) begin
            r_parity <= ~r_parity;
        end
    end
`else
    assign w_line_event = w_de_rise;
`endif

    // Actions that end in a new fetch or idle; a stuck beat defers them through DRAIN
    always_comb begin
        w_do_start   = 1'b0;
        w_do_stop    = 1'b0;
        w_do_next    = 1'b0;
        w_start_base = r_base;
        if (w_vs_rise) begin
            if (!w_beat_stuck) begin
                w_do_start   = i_enable;
                w_do_stop    = ~i_enable;
                w_start_base = i_base;
            end
        end else if (r_state == ST_DRAIN) begin
            if (!r_bus_request) begin
                w_do_start = (r_pend == PEND_START);
                w_do_stop  = (r_pend == PEND_STOP);
                w_do_next  = (r_pend == PEND_NEXT);
            end
        end else if (w_line_event &&
                     (r_state == ST_WAIT || (r_state == ST_FETCH && w_accept))) begin
            w_do_next = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pend        <= PEND_NONE;
            r_vs_prev     <= 1'b0;
            r_de_prev     <= 1'b0;
            r_line        <= 11'd0;
            r_word        <= 11'd0;
            r_base        <= 32'd0;
            r_line_addr   <= 32'd0;
            r_bus_request <= 1'b0;
            r_bus_address <= 32'd0;
            r_lb_write    <= 1'b0;
            r_lb_address  <= 12'd0;
            r_lb_wdata    <= 32'd0;
            r_read_bank   <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_vs_prev  <= i_vsync;
            r_de_prev  <= i_data_enable;
            r_lb_write <= w_accept;
            if (w_accept) begin
                r_lb_address <= {~r_read_bank, r_word};
                r_lb_wdata   <= i_bus_rdata;
            end

            if (w_do_start) begin
                r_base        <= w_start_base;
                r_line_addr   <= w_start_base;
                r_bus_address <= w_start_base;
                r_line        <= 11'd0;
                r_word        <= 11'd0;
                r_underrun    <= 1'b0;
                r_bus_request <= 1'b1;
                r_state       <= ST_FETCH;
                r_pend        <= PEND_NONE;
            end else if (w_do_stop) begin
                r_bus_request <= 1'b0;
                r_state       <= ST_IDLE;
                r_pend        <= PEND_NONE;
            end else if (w_do_next) begin
                if (r_state == ST_FETCH) begin
                    r_underrun <= 1'b1;
                end
                r_read_bank   <= ~r_read_bank;
                r_line        <= r_line + 11'd1;
                r_word        <= 11'd0;
                r_line_addr   <= w_next_line_addr;
                r_bus_address <= w_next_line_addr;
                r_bus_request <= w_more_lines;
                r_state       <= w_more_lines ? ST_FETCH : ST_IDLE;
                r_pend        <= PEND_NONE;
            end else if (w_vs_rise) begin
                // Beat still outstanding: hold the request and remember the new frame
                r_state <= ST_DRAIN;
                r_pend  <= i_enable ? PEND_START : PEND_STOP;
                if (i_enable) begin
                    r_base     <= i_base;
                    r_underrun <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (w_line_event) begin
                            r_underrun <= 1'b1;
                            r_state    <= ST_DRAIN;
                            r_pend     <= PEND_NEXT;
                        end else if (w_accept) begin
                            if (r_word == c_last_word) begin
                                r_word        <= 11'd0;
                                r_bus_request <= 1'b0;
                                r_state       <= ST_WAIT;
                            end else begin
                                r_word        <= r_word + 11'd1;
                                r_bus_address <= r_bus_address + 32'd4;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_accept) begin
                            r_bus_request <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_lb_write    = r_lb_write;
    assign o_lb_address  = r_lb_address;
    assign o_lb_wdata    = r_lb_wdata;
    assign o_read_bank   = r_read_bank;
    assign o_underrun    = r_underrun;

endmodule
`default_nettype wire
